// File: rtl/demux1_2_buf.sv
// demux1_2_buf: steers one valid/ready word stream into two independent lane FIFOs.
// Define DEMUX1_2_BUF_BYPASS_EN for zero-latency pass-through on an empty lane.
module demux1_2_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [WIDTH-1:0]                     in,
  input  logic                                 in_valid,
  input  logic                                 sel,
  output logic                                 in_ready,
  output logic [1:0][WIDTH-1:0]                out,
  output logic [1:0]                           out_valid,
  input  logic [1:0]                           out_ready,
  output logic [1:0][$clog2(DEPTH+1)-1:0]      count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [1:0] full;
  // Only registered fullness gates acceptance, so a same-cycle pop never feeds in_ready.
  assign in_ready = ~full[sel];
  for (genvar j = 0; j < 2; j++) begin : g_lane
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic [CW-1:0]    cnt;
    logic             push, pop, wr, empty;
    assign empty    = cnt == '0;
    assign full[j]  = cnt == CW'(DEPTH);
    assign push     = in_valid & in_ready & (sel == 1'(j));
    assign pop      = ~empty & out_ready[j];
    assign count[j] = cnt;
`ifdef DEMUX1_2_BUF_BYPASS_EN
    // An empty lane shows the incoming word directly; if it is taken now it never lands in storage.
    assign wr           = push & ~(empty & out_ready[j]);
    assign out_valid[j] = ~empty | (push & reset);
    assign out[j]       = (empty & push & reset) ? in : mem[rp];
`else
    assign wr           = push;
    assign out_valid[j] = ~empty;
    assign out[j]       = mem[rp];
`endif
    always_ff @(posedge clk) begin
      if (!reset) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else begin
        if (wr) begin
          mem[wp] <= in;
          wp      <= wp + 1'b1;
        end
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + CW'(wr) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_demux1_2_buf.sv
// tb_demux1_2_buf: directed vector table plus hand sequences for demux1_2_buf (DEPTH=2).
module tb_demux1_2_buf;
  logic            clk = 1'b0;
  logic            reset;
  logic [63:0]     in;
  logic            in_valid;
  logic            sel;
  logic            in_ready;
  logic [1:0][63:0] out;
  logic [1:0]      out_valid;
  logic [1:0]      out_ready;
  logic [1:0][1:0] count;
  int pass_cnt = 0;
  int total_cnt = 0;

  demux1_2_buf #(.WIDTH(64), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .sel(sel),
    .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic        sl;
    logic [63:0] d;
    logic [1:0]  ordy;
    logic        ir;
    logic [1:0]  ov;
    logic [1:0]  c0;
    logic [1:0]  c1;
    logic [63:0] o0;
    logic [63:0] o1;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total_cnt++;
    if (a !== e) $display("FAIL %s got=%h expected=%h", n, a, e);
    else pass_cnt++;
  endtask

  task automatic drive(input logic r, input logic iv, input logic sl, input logic [63:0] d, input logic [1:0] ordy);
    reset = r; in_valid = iv; sel = sl; in = d; out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b1, 1'b0, 64'hFF, 2'b00);
    tick();
`ifndef DEMUX1_2_BUF_BYPASS_EN
    //        rst  iv   sel  d        ordy   ir   ov     c0    c1    o0       o1
    vq.push_back('{1'b0,1'b1,1'b0,64'hFF,2'b00,1'b1,2'b00,2'd0,2'd0,64'h0,64'h0});
    vq.push_back('{1'b1,1'b1,1'b0,64'hA, 2'b00,1'b1,2'b00,2'd0,2'd0,64'h0,64'h0});
    vq.push_back('{1'b1,1'b1,1'b1,64'hB, 2'b00,1'b1,2'b01,2'd1,2'd0,64'hA,64'h0});
    vq.push_back('{1'b1,1'b0,1'b0,64'h0, 2'b00,1'b1,2'b11,2'd1,2'd1,64'hA,64'hB});
    vq.push_back('{1'b1,1'b0,1'b0,64'h0, 2'b11,1'b1,2'b11,2'd1,2'd1,64'hA,64'hB});
    vq.push_back('{1'b1,1'b1,1'b0,64'h1, 2'b00,1'b1,2'b00,2'd0,2'd0,64'h0,64'h0});
    vq.push_back('{1'b1,1'b1,1'b0,64'h2, 2'b00,1'b1,2'b01,2'd1,2'd0,64'h1,64'h0});
    vq.push_back('{1'b1,1'b1,1'b0,64'h3, 2'b00,1'b0,2'b01,2'd2,2'd0,64'h1,64'h0});
    vq.push_back('{1'b1,1'b1,1'b0,64'h3, 2'b01,1'b0,2'b01,2'd2,2'd0,64'h1,64'h0});
    vq.push_back('{1'b1,1'b1,1'b0,64'h3, 2'b00,1'b1,2'b01,2'd1,2'd0,64'h2,64'h0});
    vq.push_back('{1'b1,1'b0,1'b0,64'h0, 2'b01,1'b0,2'b01,2'd2,2'd0,64'h2,64'h0});
    vq.push_back('{1'b1,1'b0,1'b0,64'h0, 2'b01,1'b1,2'b01,2'd1,2'd0,64'h3,64'h0});
    vq.push_back('{1'b1,1'b0,1'b0,64'h0, 2'b00,1'b1,2'b00,2'd0,2'd0,64'h2,64'h0});
    vq.push_back('{1'b1,1'b1,1'b1,64'hC, 2'b00,1'b1,2'b00,2'd0,2'd0,64'h2,64'h0});
    vq.push_back('{1'b1,1'b1,1'b1,64'hD, 2'b10,1'b1,2'b10,2'd0,2'd1,64'h2,64'hC});
    vq.push_back('{1'b1,1'b0,1'b1,64'h0, 2'b00,1'b1,2'b10,2'd0,2'd1,64'h2,64'hD});
    vq.push_back('{1'b1,1'b0,1'b1,64'h0, 2'b10,1'b1,2'b10,2'd0,2'd1,64'h2,64'hD});
    vq.push_back('{1'b1,1'b1,1'b0,64'hE, 2'b00,1'b1,2'b00,2'd0,2'd0,64'h2,64'hC});
    vq.push_back('{1'b1,1'b1,1'b0,64'hF, 2'b00,1'b1,2'b01,2'd1,2'd0,64'hE,64'hC});
    vq.push_back('{1'b0,1'b1,1'b0,64'h7, 2'b11,1'b0,2'b01,2'd2,2'd0,64'hE,64'hC});
    vq.push_back('{1'b1,1'b0,1'b0,64'h0, 2'b11,1'b1,2'b00,2'd0,2'd0,64'h0,64'h0});
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].iv, vq[i].sl, vq[i].d, vq[i].ordy);
      chk($sformatf("v%0d.in_ready", i),  64'(in_ready),  64'(vq[i].ir));
      chk($sformatf("v%0d.out_valid", i), 64'(out_valid), 64'(vq[i].ov));
      chk($sformatf("v%0d.count0", i),    64'(count[0]),  64'(vq[i].c0));
      chk($sformatf("v%0d.count1", i),    64'(count[1]),  64'(vq[i].c1));
      chk($sformatf("v%0d.out0", i),      out[0],         vq[i].o0);
      chk($sformatf("v%0d.out1", i),      out[1],         vq[i].o1);
      tick();
    end
    // Popping both empty lanes must not underflow.
    drive(1'b1, 1'b0, 1'b0, 64'h0, 2'b00);
    chk("underflow.count0", 64'(count[0]), 64'd0);
    chk("underflow.count1", 64'(count[1]), 64'd0);
    chk("underflow.out_valid", 64'(out_valid), 64'd0);
    // Latency: pushed word visible only after the edge.
    drive(1'b1, 1'b1, 1'b1, 64'h99, 2'b00);
    chk("latency.pre", 64'(out_valid), 64'b00);
    tick();
    drive(1'b1, 1'b0, 1'b1, 64'h0, 2'b10);
    chk("latency.valid", 64'(out_valid), 64'b10);
    chk("latency.out1", out[1], 64'h99);
    tick();
    chk("latency.drained", 64'(count[1]), 64'd0);
`else
    drive(1'b1, 1'b0, 1'b0, 64'h0, 2'b00);
    tick();
    drive(1'b1, 1'b1, 1'b1, 64'h5, 2'b10);
    chk("bypass.out1", out[1], 64'h5);
    chk("bypass.valid1", 64'(out_valid[1]), 64'd1);
    chk("bypass.in_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 64'h0, 2'b00);
    chk("bypass.count1", 64'(count[1]), 64'd0);
    chk("bypass.valid_after", 64'(out_valid), 64'b00);
    drive(1'b1, 1'b1, 1'b0, 64'h6, 2'b00);
    chk("bypass.hold_valid0", 64'(out_valid[0]), 64'd1);
    chk("bypass.hold_out0", out[0], 64'h6);
    tick();
    drive(1'b1, 1'b0, 1'b0, 64'h0, 2'b00);
    chk("bypass.stored_count0", 64'(count[0]), 64'd1);
    chk("bypass.stored_out0", out[0], 64'h6);
    chk("bypass.stored_valid", 64'(out_valid), 64'b01);
    chk("bypass.stored_count1", 64'(count[1]), 64'd0);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/demux1_2_buf.md
# demux1_2_buf

Buffered 1-to-2 demultiplexer: the write-side counterpart of the 2:1 word mux in the datapath. Accepts one WIDTH-bit word per cycle on a valid/ready input and steers it by `sel` into one of two independent per-lane FIFOs. Each lane drains through its own valid/ready port. Used where a single producer, such as a writeback or forwarding source, feeds two consumers that stall independently.

## Interface
- `WIDTH`, 64, data word width in bits.
- `DEPTH`, 2, entries per lane FIFO; power of two, ≥2.

- `clk`  input  1  rising-edge clock for all state.
- `reset`  input  1  synchronous, active-low; sampled on `clk`.
- `in`  input  WIDTH  data word offered by the producer.
- `in_valid`  input  1  producer has a word on `in`.
- `sel`  input  1  target lane for the word on `in` (0 or 1); qualified by `in_valid`.
- `in_ready`  output  1  the lane addressed by `sel` can accept a word this cycle.
- `out`  output  [1:0][WIDTH-1:0]  head word of each lane; `out[j]` is lane j.
- `out_valid`  output  2  bit j set: lane j holds at least one word.
- `out_ready`  input  2  bit j set: consumer j takes `out[j]` this cycle.
- `count`  output  [1:0][$clog2(DEPTH+1)-1:0]  occupancy of each lane.

## Operation
- Push to lane j occurs when `in_valid & in_ready & (sel==j)`. `in_ready = ~full[sel]`, where full means `count[sel]==DEPTH`.
- `in_ready` ignores a same-cycle pop, so there is no combinational path from `out_ready` to `in_ready`.
- Pop from lane j occurs when `out_valid[j] & out_ready[j]`. `out_valid[j] = (count[j]!=0)`.
- Each lane is a circular buffer with a write pointer, a read pointer and a count. Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH with no extra logic.
- Push only on lane j: count +1, write pointer +1. Pop only: count −1, read pointer +1. Push and pop on the same lane in the same cycle: count unchanged, both pointers advance.
- A push to one lane and a pop from the other lane in the same cycle are independent and both take effect.
- Words leave each lane in the order they entered it. There is no ordering guarantee across lanes.
- `out[j]` is driven from the storage word at lane j's read pointer. It holds its value while `out_valid[j]` is set and `out_ready[j]` is low.
- When `in_valid` is low, `sel` and `in` are don't-care. A word offered while `in_ready` is low is not captured; the producer must hold it.
- `out_ready[j]` while `out_valid[j]` is low has no effect. The count never underflows.

## Timing
- Reset (`reset==0` at a `clk` edge):
  - all counts and pointers go to 0, all storage goes to 0;
  - `out` = 0, `out_valid` = 2'b00, `count` = 0;
  - `in_ready` = 1;
  - words held before reset are discarded, including a push or pop in the reset cycle.
- Latency without the configuration option: a word pushed at edge N is visible with `out_valid[j]=1` after edge N. It can be popped at edge N+1 at the earliest.
- Throughput: one push per cycle into any non-full lane, and one pop per cycle per lane.
- On a full lane, a push is refused (`in_ready` low) even if that lane pops in the same cycle. `in_ready` rises the cycle after the pop.
- All outputs except `in_ready` are registered or decoded only from registered state. `in_ready` is combinational from `sel` and registered counts.

## Configuration
- `DEMUX1_2_BUF_BYPASS_EN`
  - Defined: when lane j is empty, a push to lane j sets `out_valid[j]` and drives `out[j]=in` combinationally in the same cycle.
  - If `out_ready[j]` is also high in that cycle, the word passes straight through. It is never written to storage, and count and pointers are unchanged.
  - Zero latency applies only to an empty lane. Non-empty lane behaviour is unchanged.
- Not defined: no path from `in` to `out`, and latency is a fixed 1 cycle as in Timing.

## Test plan
- Reset: hold `reset=0` for 2 cycles with `in_valid=1`.
  - During reset, `out_valid=00`, `count` both 0, `out` both 0, no push.
  - After release, `in_ready=1`.
- Steering: push 64'hA (`sel=0`) then 64'hB (`sel=1`) with `out_ready=00`.
  - `out[0]=A`, `out[1]=B`, `out_valid=11`, counts 1/1.
- Full and wrap on lane 0 (DEPTH=2):
  - Push 1, 2, 3 on lane 0; the third is refused (`in_ready=0`), count 2.
  - Pop once, then push 3; pops then return 2 then 3 as the pointers wrap.
  - `count` returns to 0.
- Simultaneous push and pop on lane 1 holding one word: count stays 1 and order is preserved.
- Full-lane refusal: lane 0 full with `out_ready[0]=1` and `sel=0`, `in_valid=1`. `in_ready=0` that cycle and 1 the next.
- Mid-operation reset with lane 0 holding 2 words: assert `reset=0` for one edge. Then `count=0` and `out_valid=00`; the words are lost.
- With `DEMUX1_2_BUF_BYPASS_EN` defined: empty lane 1, push 64'h5 with `out_ready[1]=1`.
  - `out[1]=5` and `out_valid[1]=1` in the same cycle.
  - The count stays 0.
